// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-2 Booth multiplier, one Booth step per clock
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         request; sampled only in IDLE or DONE
//   signed_mode   1 = two's complement operands, 0 = unsigned; latched with operands
//   multiplicand  WIDTH-bit operand added/subtracted into the accumulator
//   multiplier    WIDTH-bit operand scanned by the Booth recoder
//   busy          high while an operation is in progress (RUN)
//   done          single-cycle pulse; product valid
//   product       2*WIDTH-bit result; holds last result until the next completion

module booth_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state;
   logic [WIDTH:0]     m_ext;
   logic [WIDTH+1:0]   acc;
   logic [WIDTH:0]     q;
   logic               q_prev;
   logic [CW-1:0]      cnt;

   // Operands get one extra bit so unsigned values look like positive signed
   // values; the Booth recoder then treats both modes identically.
   logic [WIDTH:0]     mcand_ext;
   logic [WIDTH:0]     mplier_ext;
   logic [WIDTH+1:0]   m_wide;
   logic [WIDTH+1:0]   acc_sum;
   logic [WIDTH+1:0]   acc_next;
   logic [WIDTH:0]     q_next;

   assign mcand_ext  = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
   assign mplier_ext = signed_mode ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};
   assign m_wide     = {m_ext[WIDTH], m_ext};

   always_comb begin
      acc_sum = acc;
      case ({q[0], q_prev})
         2'b10:   acc_sum = acc - m_wide;
         2'b01:   acc_sum = acc + m_wide;
         default: acc_sum = acc;
      endcase
   end

   // Arithmetic shift of {acc, q, q_prev} right by one; q_prev takes q[0].
   assign acc_next = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
   assign q_next   = {acc_sum[0], q[WIDTH:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         m_ext   <= '0;
         acc     <= '0;
         q       <= '0;
         q_prev  <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  m_ext  <= mcand_ext;
                  acc    <= '0;
                  q      <= mplier_ext;
                  q_prev <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_RUN: begin
               acc    <= acc_next;
               q      <= q_next;
               q_prev <= q[0];
               cnt    <= cnt + CW'(1);
               // WIDTH+1 steps cover the extended multiplier; the low 2*WIDTH
               // bits of {acc, q} after the last shift are the exact product.
               if (cnt == CW'(WIDTH)) begin
                  product <= {acc_next[WIDTH-2:0], q_next};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed and swept checks of booth_mul_seq at WIDTH 4, 8 and 16

module tb_booth_mul_seq;

   logic clk;
   logic rst;

   logic        start8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        start4, sm4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

   logic        start16, sm16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int checks = 0;
   int errors = 0;
   logic [15:0] last8 = '0;
   logic d8_q = 1'b0, d4_q = 1'b0, d16_q = 1'b0;

   booth_mul_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(p8)
   );

   booth_mul_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .multiplicand(a4), .multiplier(b4), .busy(busy4), .done(done4), .product(p4)
   );

   booth_mul_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .multiplicand(a16), .multiplier(b16), .busy(busy16), .done(done16), .product(p16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input bit sm, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
      longint sa, sb;
      logic [63:0] mask;
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[w-1]) sa = sa - (longint'(1) << w);
      if (sm && b[w-1]) sb = sb - (longint'(1) << w);
      mask = (64'd1 << (2 * w)) - 64'd1;
      return 64'(sa * sb) & mask;
   endfunction

   // Handshake monitor: busy/done exclusive, done never longer than one cycle.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert (!(busy8 && done8) && !(done8 && d8_q)) else begin
            errors++;
            $error("FAIL w8_handshake: busy=%0b done=%0b prev_done=%0b required exclusive single-cycle done",
                   busy8, done8, d8_q);
         end
         checks++;
         assert (!(busy4 && done4) && !(done4 && d4_q)) else begin
            errors++;
            $error("FAIL w4_handshake: busy=%0b done=%0b prev_done=%0b required exclusive single-cycle done",
                   busy4, done4, d4_q);
         end
         checks++;
         assert (!(busy16 && done16) && !(done16 && d16_q)) else begin
            errors++;
            $error("FAIL w16_handshake: busy=%0b done=%0b prev_done=%0b required exclusive single-cycle done",
                   busy16, done16, d16_q);
         end
      end
      d8_q  = done8;
      d4_q  = done4;
      d16_q = done16;
   end

   // One WIDTH=8 operation with exact latency checks; inputs are scrambled and
   // start is re-pulsed during RUN to show they are ignored.
   task automatic run_op8(input string tag, input logic sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
      int bad;
      @(negedge clk);
      start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      bad = 0;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         if (busy8 !== 1'b1 || done8 !== 1'b0 || p8 !== last8) bad++;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         sm8 = 1'($urandom);
         start8 = (k == 3);
      end
      start8 = 1'b0;
      check({tag, "_run_window"}, 64'(bad), 64'd0);
      @(negedge clk);
      check({tag, "_done"}, {62'd0, busy8, done8}, 64'b01);
      check({tag, "_product"}, 64'(p8), 64'(exp));
      last8 = exp;
      @(negedge clk);
      check({tag, "_idle"}, {62'd0, busy8, done8}, 64'b00);
      check({tag, "_hold"}, 64'(p8), 64'(exp));
   endtask

   task automatic rand_op4(input int idx);
      int n;
      logic [63:0] exp;
      @(negedge clk);
      start4 = 1'b1; sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      exp = ref_mul(sm4, 64'(a4), 64'(b4), 4);
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("w4_lat_%0d", idx), 64'(n), 64'd5);
      check($sformatf("w4_prod_%0d", idx), 64'(p4), exp);
   endtask

   task automatic rand_op16(input int idx);
      int n;
      logic [63:0] exp;
      @(negedge clk);
      start16 = 1'b1; sm16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      if (idx == 0) begin a16 = 16'h8000; b16 = 16'h8000; sm16 = 1'b1; end
      if (idx == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; sm16 = 1'b0; end
      exp = ref_mul(sm16, 64'(a16), 64'(b16), 16);
      @(negedge clk);
      start16 = 1'b0;
      n = 0;
      while (done16 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("w16_lat_%0d", idx), 64'(n), 64'd17);
      check($sformatf("w16_prod_%0d", idx), 64'(p16), exp);
   endtask

   initial begin
      int bad;
      logic [63:0] r;
      logic sm;
      logic [7:0] ra, rb;

      rst = 1'b1;
      start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
      start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
      start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
      @(negedge clk);
      check("reset_outputs", {46'd0, busy8, done8, p8}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed WIDTH=8 vectors
      run_op8("s_m7x3",       1'b1, 8'hF9, 8'h03, 16'hFFEB);
      run_op8("s_m128xm128",  1'b1, 8'h80, 8'h80, 16'h4000);
      run_op8("s_m128x127",   1'b1, 8'h80, 8'h7F, 16'hC080);
      run_op8("s_0xm1",       1'b1, 8'h00, 8'hFF, 16'h0000);
      run_op8("u_255x255",    1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run_op8("u_200x3",      1'b0, 8'hC8, 8'h03, 16'h0258);
      run_op8("s_ffxff",      1'b1, 8'hFF, 8'hFF, 16'h0001);
      run_op8("u_0x255",      1'b0, 8'hFF, 8'h00, 16'h0000);

      // Back-to-back: start held high; op A (5*-3 signed), op B (17*13 unsigned)
      @(negedge clk);
      start8 = 1'b1; sm8 = 1'b1; a8 = 8'd5; b8 = 8'hFD;
      @(negedge clk);
      sm8 = 1'b0; a8 = 8'd17; b8 = 8'd13;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         if (done8 !== ((i == 9) || (i == 19))) bad++;
         if (busy8 !== !((i == 9) || (i == 19))) bad++;
         if (i < 9 && p8 !== last8) bad++;
         if (i >= 10 && i < 19 && p8 !== 16'hFFF1) bad++;
         if (i == 9) check("b2b_prod_a", 64'(p8), 64'hFFF1);
         if (i == 19) check("b2b_prod_b", 64'(p8), 64'h00DD);
         if (i == 10) begin a8 = 8'h01; b8 = 8'h01; sm8 = 1'b1; end
         if (i == 19) start8 = 1'b0;
      end
      check("b2b_pulse_pattern", 64'(bad), 64'd0);
      last8 = 16'h00DD;
      @(negedge clk);
      check("b2b_idle", {46'd0, busy8, done8, p8}, {46'd0, 2'b00, 16'h00DD});

      // Asynchronous reset in the 4th RUN cycle
      @(negedge clk);
      start8 = 1'b1; sm8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_reset", {46'd0, busy8, done8, p8}, 64'd0);
      last8 = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {62'd0, busy8, done8}, 64'd0);
      run_op8("after_reset", 1'b1, 8'h12, 8'h34, 16'h03A8);

      // Swept operands against the reference multiply
      for (int i = 0; i < 10; i++) begin
         sm = 1'($urandom);
         ra = 8'($urandom);
         rb = 8'($urandom);
         r = ref_mul(sm, 64'(ra), 64'(rb), 8);
         run_op8($sformatf("w8_rand_%0d", i), sm, ra, rb, r[15:0]);
      end
      for (int i = 0; i < 20; i++) rand_op4(i);
      for (int i = 0; i < 20; i++) rand_op16(i);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Iterative radix-2 Booth multiplier. Parametrised operand width; selectable signed or unsigned operands.
- Computes one Booth step per clock.
- Uses a start/busy/done handshake so a controller or datapath sequencer can share one small multiplier across many operations.
- Successor to the team's combinational 4-bit Booth multiplier, which has no mode select, no pipelining and a fixed width.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2; product width is 2*WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
signed_mode  input  1  1 = operands are two's complement; 0 = unsigned; latched with operands
multiplicand  input  WIDTH  operand added/subtracted into the accumulator
multiplier  input  WIDTH  operand whose bits are scanned by the Booth recoder
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  single-cycle pulse; product valid
product  output  2*WIDTH  result register; holds last result until the next completion

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, all internal registers 0. Applies immediately, including mid-operation; the in-flight operation is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - Latch operands extended to WIDTH+1 bits: sign-extend if signed_mode=1, zero-extend if 0.
  - Initialise: accumulator=0, Q=extended multiplier, q_prev=0, step counter=0.
  - Go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge performs one Booth step:
  - {Q[0],q_prev}: 10 -> acc = acc - M; 01 -> acc = acc + M; 00 or 11 -> no change.
  - Here M is the extended multiplicand and acc is WIDTH+2 bits wide, which prevents intermediate overflow.
  - Then arithmetic-shift {acc,Q,q_prev} right by one, replicating the acc MSB.
  - Increment the counter.
  - After WIDTH+1 steps, go to DONE and load product with the low 2*WIDTH bits of {acc,Q} from the final step. This is exact for both modes.
- DONE: lasts exactly one cycle with done=1.
  - start=1 at this edge: accept a new operation (-> RUN, same init as IDLE). Back-to-back throughput is one result per WIDTH+2 cycles.
  - Otherwise -> IDLE.
- Latency: start sampled at edge E0; busy=1 from E0 to E(WIDTH+1); done=1 and new product visible from E(WIDTH+1) to E(WIDTH+2). Fixed and identical for both modes.
- busy=1 exactly in RUN. done=1 exactly in DONE. busy and done are never both high.
- start while in RUN is ignored. Operand and signed_mode changes during RUN have no effect.
- product changes only on entry to DONE (or reset). It is stable in IDLE and RUN.
- Boundary values must be exact:
  - signed -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2WIDTH-2)
  - unsigned (2^WIDTH-1)^2
  - any operand 0 -> 0

Test Plan:
- Reset, then WIDTH=8, signed_mode=1, multiplicand=-7 (0xF9), multiplier=3, start pulse -> busy high 9 cycles, done pulses on cycle 9 after start edge, product=0xFFEB (-21).
- WIDTH=8 signed: -128*-128 -> 0x4000. -128*127 -> 0xC080. 0*-1 -> 0x0000.
- WIDTH=8 unsigned: 255*255 -> 0xFE01. 200*3 -> 0x0258. Same bit patterns 0xFF*0xFF with signed_mode=1 -> 0x0001.
- Start held high continuously with new operands in the DONE cycle -> back-to-back operations, one done pulse per 10 cycles. Product from op N is held until op N+1's done. Start and operand toggles during RUN are ignored.
- Assert rst on the 4th RUN cycle -> busy=0, done=0, product=0 immediately (asynchronous). A fresh start afterwards gives the correct result with normal latency.
- Randomised sweep at WIDTH=4, 8 and 16, both modes, against a reference multiply. Check that busy/done are mutually exclusive and that done is a single-cycle pulse.
